cp0_exc_sequencer: RTL and testbench
====================================

# cp0_exc_sequencer

Exception entry/return sequencer for CP0: accepts exception, NMI, interrupt and ERET requests from the pipeline and drives the status unit's write port (`we_s`/`write_data`), consuming its `read_data`. It maintains a hardware stack of {status, EPC} pairs so nested exceptions restore the exact prior status on ERET. It also issues the pipeline flush and PC redirect for every sequence.

## Interface
- DEPTH, 4: nesting stack entries (1..8).
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- exc_req  in  1  synchronous exception request (level, held until ack).
- exc_code  in  5  cause code for exc_req; sampled at acceptance.
- nmi_req  in  1  non-maskable interrupt request.
- eret_req  in  1  ERET retiring.
- epc_in  in  32  PC of the faulting or interrupted instruction; sampled at acceptance.
- int_pending  in  8  interrupt lines, IP[7:0].
- status_in  in  32  current status register (from status unit read_data).
- ack  out  1  one-cycle pulse: request accepted.
- flush  out  1  one-cycle pipeline flush.
- we_s  out  1  status write enable, one cycle.
- status_wdata  out  32  status write value.
- redirect_valid  out  1  one-cycle pulse with redirect_pc.
- redirect_pc  out  32  fetch target.
- cause_code  out  5  code of the last accepted exception (0 = interrupt).
- depth  out  4  stack occupancy, 0..DEPTH.
- overflow  out  1  sticky: push attempted while full.
- underflow  out  1  sticky: ERET with empty stack.

## Operation
- Status bits: IE[0], EXL[1], ERL[2], UM[4], IM[15:8], BEV[22].
- int_take = IE & ~EXL & ~ERL & |(int_pending & IM), using status_in.
- Acceptance happens only in IDLE. Priority: nmi_req > exc_req > int_take > eret_req. Lower-priority requests are not acked and must be held by the requester.
- At acceptance, snapshot S = status_in and P = epc_in. Set cause_code to exc_code, 0 for an interrupt, or 31 for NMI.
- FSM states: IDLE, FLUSH, SAVE, POP, WRITE, REDIR.
  - Entry: IDLE→FLUSH→SAVE→WRITE→REDIR→IDLE.
  - ERET: IDLE→FLUSH→POP→WRITE→REDIR→IDLE.
- SAVE: push {S,P} and increment depth. If depth==DEPTH, do not push, leave depth unchanged and set overflow. The entry sequence still completes.
- WRITE, exception or interrupt: status_wdata = S with EXL=1 and UM=0; all other bits unchanged.
- WRITE, NMI: status_wdata = S with ERL=1, BEV=1 and UM=0.
- WRITE, ERET: status_wdata = popped status.
- WRITE, ERET on an empty stack: status_wdata = S with EXL=0 and ERL=0; set underflow.
- Redirect targets:
  - NMI: 32'hBFC00000.
  - Exception or interrupt with S.BEV=1: 32'hBFC00380.
  - Exception or interrupt with S.BEV=0: 32'h80000180.
  - ERET: popped EPC, or P when the stack is empty.
- POP: decrement depth and latch the top entry.

## Timing
- Request present in IDLE at cycle N. Cycle N+1 (FLUSH): ack=1 and flush=1.
- N+2 is SAVE or POP. N+3: we_s=1. N+4: redirect_valid=1. N+5: IDLE, and a new request can be accepted.
- All outputs are registered.
- Reset values:
  - Outputs: all 0 (including status_wdata, redirect_pc, cause_code, depth, overflow, underflow).
  - FSM state: IDLE.
  - Stack: contents don't-care.
- Reset asserted mid-sequence aborts it immediately. No we_s or redirect_valid is issued after reset deasserts.
- Request changes after acceptance are ignored until the sequencer returns to IDLE.
- status_in is used only at acceptance. The status unit's own update of status from we_s at N+3 does not affect the current sequence.

## Test plan
- Exception code 5 with epc_in=0x00400010 and status=0x0000FF01: ack at N+1; we_s at N+3 with wdata=0x0000FF03; redirect_pc=0x80000180 at N+4; depth=1.
- Then ERET: we_s with wdata=0x0000FF01; redirect_pc=0x00400010; depth=0.
- Simultaneous nmi_req and exc_req with status=0x00000001: NMI taken, wdata=0x00400005, redirect_pc=0xBFC00000, cause_code=31. exc_req is acked on the next IDLE cycle.
- Interrupt gating:
  - status=0x00000401 with int_pending=0x04: taken, cause_code=0.
  - The same with EXL set (status=0x00000403): not taken.
- DEPTH+1 nested exceptions: depth saturates at DEPTH and overflow=1. Then DEPTH ERETs restore the pushed statuses in LIFO order.
- ERET with depth=0 and status=0x00000006: wdata=0x00000000, redirect_pc=epc_in, underflow=1.
- rst low during WRITE: all outputs 0 asynchronously. After release, no redirect occurs and depth=0.

Source files
------------

// File: rtl/cp0_exc_sequencer.sv
// rtl/cp0_exc_sequencer.sv - CP0 exception entry / ERET sequencer with nested status stack
//
// Accepts NMI, synchronous exception, interrupt and ERET requests from the
// pipeline. Each accepted request runs a fixed five-cycle sequence:
//   entry : IDLE -> FLUSH -> SAVE -> WRITE -> REDIR -> IDLE
//   eret  : IDLE -> FLUSH -> POP  -> WRITE -> REDIR -> IDLE
// A hardware stack of {status, EPC} pairs lets nested exceptions restore the
// exact prior status on ERET.
//
// Ports
//   clk            in   clock, rising edge
//   rst            in   asynchronous active-low reset
//   exc_req        in   exception request (level, held until ack)
//   exc_code[4:0]  in   cause code for exc_req, sampled at acceptance
//   nmi_req        in   non-maskable interrupt request
//   eret_req       in   ERET retiring
//   epc_in[31:0]   in   PC of faulting/interrupted instruction, sampled at acceptance
//   int_pending[7:0] in interrupt lines IP[7:0]
//   status_in[31:0] in  current status register
//   ack            out  one-cycle pulse: request accepted
//   flush          out  one-cycle pipeline flush
//   we_s           out  one-cycle status write enable
//   status_wdata[31:0] out status write value
//   redirect_valid out  one-cycle pulse qualifying redirect_pc
//   redirect_pc[31:0] out fetch target
//   cause_code[4:0] out code of last accepted exception (0 = interrupt, 31 = NMI)
//   depth[3:0]     out  stack occupancy, 0..DEPTH
//   overflow       out  sticky: push attempted while stack full
//   underflow      out  sticky: ERET with empty stack

module cp0_exc_sequencer #(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        exc_req,
    input  logic [4:0]  exc_code,
    input  logic        nmi_req,
    input  logic        eret_req,
    input  logic [31:0] epc_in,
    input  logic [7:0]  int_pending,
    input  logic [31:0] status_in,
    output logic        ack,
    output logic        flush,
    output logic        we_s,
    output logic [31:0] status_wdata,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc,
    output logic [4:0]  cause_code,
    output logic [3:0]  depth,
    output logic        overflow,
    output logic        underflow
);

    localparam logic [3:0]  DEPTH_W   = 4'(DEPTH);

    // Status register bit positions
    localparam int IE_B  = 0;
    localparam int EXL_B = 1;
    localparam int ERL_B = 2;
    localparam int UM_B  = 4;
    localparam int BEV_B = 22;

    localparam logic [31:0] NMI_VEC      = 32'hBFC0_0000;
    localparam logic [31:0] BOOT_EXC_VEC = 32'hBFC0_0380;
    localparam logic [31:0] EXC_VEC      = 32'h8000_0180;

    typedef enum logic [2:0] {
        IDLE,
        FLUSH,
        SAVE,
        POP,
        WRITE,
        REDIR
    } state_t;

    typedef enum logic [1:0] {
        K_EXC,      // synchronous exception or interrupt
        K_NMI,
        K_ERET
    } kind_t;

    state_t      state;
    kind_t       kind;
    logic [31:0] snap_s;        // status_in captured at acceptance
    logic [31:0] snap_p;        // epc_in captured at acceptance
    logic [31:0] target;        // redirect target decided in SAVE/POP

    // Stack storage is not reset: entries above depth are never read.
    logic [31:0] stack_s [0:7];
    logic [31:0] stack_p [0:7];

    logic        int_take;
    logic [2:0]  top_idx;
    logic        push_ok;

    assign int_take = status_in[IE_B] & ~status_in[EXL_B] & ~status_in[ERL_B]
                    & (|(int_pending & status_in[15:8]));

    assign top_idx  = depth[2:0] - 3'd1;
    assign push_ok  = (depth != DEPTH_W);

    always_ff @(posedge clk) begin
        if (state == SAVE && push_ok) begin
            stack_s[depth[2:0]] <= snap_s;
            stack_p[depth[2:0]] <= snap_p;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state          <= IDLE;
            kind           <= K_EXC;
            snap_s         <= 32'd0;
            snap_p         <= 32'd0;
            target         <= 32'd0;
            ack            <= 1'b0;
            flush          <= 1'b0;
            we_s           <= 1'b0;
            status_wdata   <= 32'd0;
            redirect_valid <= 1'b0;
            redirect_pc    <= 32'd0;
            cause_code     <= 5'd0;
            depth          <= 4'd0;
            overflow       <= 1'b0;
            underflow      <= 1'b0;
        end else begin
            // Pulse outputs default low; each is raised for exactly one state.
            ack            <= 1'b0;
            flush          <= 1'b0;
            we_s           <= 1'b0;
            redirect_valid <= 1'b0;

            case (state)
                IDLE: begin
                    if (nmi_req || exc_req || int_take || eret_req) begin
                        state  <= FLUSH;
                        ack    <= 1'b1;
                        flush  <= 1'b1;
                        snap_s <= status_in;
                        snap_p <= epc_in;
                        if (nmi_req) begin
                            kind       <= K_NMI;
                            cause_code <= 5'd31;
                        end else if (exc_req) begin
                            kind       <= K_EXC;
                            cause_code <= exc_code;
                        end else if (int_take) begin
                            kind       <= K_EXC;
                            cause_code <= 5'd0;
                        end else begin
                            // ERET leaves cause_code describing the last exception.
                            kind <= K_ERET;
                        end
                    end
                end

                FLUSH: begin
                    state <= (kind == K_ERET) ? POP : SAVE;
                end

                SAVE: begin
                    // A full stack drops the push but the entry still completes.
                    if (push_ok) begin
                        depth <= depth + 4'd1;
                    end else begin
                        overflow <= 1'b1;
                    end
                    we_s <= 1'b1;
                    if (kind == K_NMI) begin
                        status_wdata        <= snap_s;
                        status_wdata[ERL_B] <= 1'b1;
                        status_wdata[BEV_B] <= 1'b1;
                        status_wdata[UM_B]  <= 1'b0;
                        target              <= NMI_VEC;
                    end else begin
                        status_wdata        <= snap_s;
                        status_wdata[EXL_B] <= 1'b1;
                        status_wdata[UM_B]  <= 1'b0;
                        target              <= snap_s[BEV_B] ? BOOT_EXC_VEC : EXC_VEC;
                    end
                    state <= WRITE;
                end

                POP: begin
                    we_s <= 1'b1;
                    if (depth == 4'd0) begin
                        // No saved context: just drop out of exception level.
                        underflow           <= 1'b1;
                        status_wdata        <= snap_s;
                        status_wdata[EXL_B] <= 1'b0;
                        status_wdata[ERL_B] <= 1'b0;
                        target              <= snap_p;
                    end else begin
                        depth        <= depth - 4'd1;
                        status_wdata <= stack_s[top_idx];
                        target       <= stack_p[top_idx];
                    end
                    state <= WRITE;
                end

                WRITE: begin
                    redirect_valid <= 1'b1;
                    redirect_pc    <= target;
                    state          <= REDIR;
                end

                REDIR: begin
                    state <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cp0_exc_sequencer.sv
// tb/tb_cp0_exc_sequencer.sv - directed self-checking bench for cp0_exc_sequencer
module tb_cp0_exc_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        exc_req = 1'b0;
    logic [4:0]  exc_code = 5'd0;
    logic        nmi_req = 1'b0;
    logic        eret_req = 1'b0;
    logic [31:0] epc_in = 32'd0;
    logic [7:0]  int_pending = 8'd0;
    logic [31:0] status_in = 32'd0;
    logic        ack;
    logic        flush;
    logic        we_s;
    logic [31:0] status_wdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic [4:0]  cause_code;
    logic [3:0]  depth;
    logic        overflow;
    logic        underflow;

    int errors = 0;
    int checks = 0;

    cp0_exc_sequencer #(.DEPTH(4)) dut (
        .clk(clk),
        .rst(rst),
        .exc_req(exc_req),
        .exc_code(exc_code),
        .nmi_req(nmi_req),
        .eret_req(eret_req),
        .epc_in(epc_in),
        .int_pending(int_pending),
        .status_in(status_in),
        .ack(ack),
        .flush(flush),
        .we_s(we_s),
        .status_wdata(status_wdata),
        .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc),
        .cause_code(cause_code),
        .depth(depth),
        .overflow(overflow),
        .underflow(underflow)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Caller sets up requests/inputs just after a negedge with the DUT idle.
    // Walks the five cycles N+1..N+5 and checks each registered output.
    task automatic expect_seq(input string tag, input logic keep_exc,
                              input logic [31:0] exp_wdata, input logic [31:0] exp_pc,
                              input logic [3:0] exp_depth);
        @(negedge clk);                                   // N+1
        check({tag, ".ack"}, 32'(ack), 32'd1);
        check({tag, ".flush"}, 32'(flush), 32'd1);
        nmi_req  = 1'b0;
        eret_req = 1'b0;
        exc_req  = keep_exc;
        @(negedge clk);                                   // N+2
        check({tag, ".we_early"}, 32'(we_s), 32'd0);
        @(negedge clk);                                   // N+3
        check({tag, ".we"}, 32'(we_s), 32'd1);
        check({tag, ".wdata"}, status_wdata, exp_wdata);
        @(negedge clk);                                   // N+4
        check({tag, ".rv"}, 32'(redirect_valid), 32'd1);
        check({tag, ".pc"}, redirect_pc, exp_pc);
        check({tag, ".depth"}, 32'(depth), 32'(exp_depth));
        check({tag, ".ack_held"}, 32'(ack), 32'd0);
        @(negedge clk);                                   // N+5
        check({tag, ".rv_end"}, 32'(redirect_valid), 32'd0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        exc_req = 1'b0; nmi_req = 1'b0; eret_req = 1'b0; int_pending = 8'd0;
        @(negedge clk);
        rst = 1'b1;
    endtask

    logic [31:0] st [0:4];
    logic [31:0] ep [0:4];
    logic        seen;

    initial begin
        // Reset state
        repeat (2) @(negedge clk);
        check("rst.ack", 32'(ack), 32'd0);
        check("rst.we", 32'(we_s), 32'd0);
        check("rst.wdata", status_wdata, 32'd0);
        check("rst.rv", 32'(redirect_valid), 32'd0);
        check("rst.pc", redirect_pc, 32'd0);
        check("rst.cause", 32'(cause_code), 32'd0);
        check("rst.depth", 32'(depth), 32'd0);
        check("rst.flags", {30'd0, overflow, underflow}, 32'd0);
        rst = 1'b1;
        @(negedge clk);

        // Exception entry then ERET
        exc_req = 1'b1; exc_code = 5'd5; epc_in = 32'h0040_0010; status_in = 32'h0000_FF01;
        expect_seq("exc5", 1'b0, 32'h0000_FF03, 32'h8000_0180, 4'd1);
        check("exc5.cause", 32'(cause_code), 32'd5);
        eret_req = 1'b1; status_in = 32'h0000_FF03; epc_in = 32'hDEAD_0000;
        expect_seq("eret1", 1'b0, 32'h0000_FF01, 32'h0040_0010, 4'd0);
        check("eret1.uf", 32'(underflow), 32'd0);

        // NMI beats simultaneous exception; exception taken next IDLE
        nmi_req = 1'b1; exc_req = 1'b1; exc_code = 5'd7; status_in = 32'h0000_0001; epc_in = 32'h0000_1234;
        expect_seq("nmi", 1'b1, 32'h0040_0005, 32'hBFC0_0000, 4'd1);
        check("nmi.cause", 32'(cause_code), 32'd31);
        expect_seq("exc_after_nmi", 1'b0, 32'h0000_0003, 32'h8000_0180, 4'd2);
        check("exc_after_nmi.cause", 32'(cause_code), 32'd7);
        do_reset();
        check("reset2.depth", 32'(depth), 32'd0);

        // Interrupt gating
        status_in = 32'h0000_0401; int_pending = 8'h04; epc_in = 32'h0000_2000;
        expect_seq("int", 1'b0, 32'h0000_0403, 32'h8000_0180, 4'd1);
        check("int.cause", 32'(cause_code), 32'd0);
        status_in = 32'h0000_0403;
        seen = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (ack) seen = 1'b1;
        end
        check("int_exl_blocked", 32'(seen), 32'd0);
        int_pending = 8'h00;
        do_reset();

        // DEPTH+1 nested exceptions: BEV=1, UM=1 statuses
        for (int i = 0; i < 5; i++) begin
            st[i] = 32'h0040_0010 | (32'(i) << 8);
            ep[i] = 32'h0000_1000 + 32'(4 * i);
        end
        for (int i = 0; i < 5; i++) begin
            exc_req = 1'b1; exc_code = 5'd4; status_in = st[i]; epc_in = ep[i];
            expect_seq($sformatf("nest%0d", i), 1'b0, 32'h0040_0002 | (32'(i) << 8),
                       32'hBFC0_0380, (i < 4) ? 4'(i + 1) : 4'd4);
            check($sformatf("nest%0d.ovf", i), 32'(overflow), (i == 4) ? 32'd1 : 32'd0);
        end
        for (int i = 3; i >= 0; i--) begin
            eret_req = 1'b1; status_in = 32'h0000_0002; epc_in = 32'hFFFF_0000;
            expect_seq($sformatf("pop%0d", i), 1'b0, st[i], ep[i], 4'(i));
        end
        check("pop.ovf_sticky", 32'(overflow), 32'd1);
        check("pop.uf", 32'(underflow), 32'd0);

        // ERET with empty stack
        eret_req = 1'b1; status_in = 32'h0000_0006; epc_in = 32'hABCD_0000;
        expect_seq("eret_empty", 1'b0, 32'h0000_0000, 32'hABCD_0000, 4'd0);
        check("eret_empty.uf", 32'(underflow), 32'd1);
        do_reset();

        // Reset asserted during WRITE
        exc_req = 1'b1; exc_code = 5'd2; status_in = 32'h0000_FF01; epc_in = 32'h0000_3000;
        @(negedge clk);
        exc_req = 1'b0;
        repeat (2) @(negedge clk);
        check("abort.we_before", 32'(we_s), 32'd1);
        rst = 1'b0;
        #1;
        check("abort.we", 32'(we_s), 32'd0);
        check("abort.wdata", status_wdata, 32'd0);
        check("abort.cause", 32'(cause_code), 32'd0);
        check("abort.depth", 32'(depth), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        seen = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (redirect_valid || we_s || ack) seen = 1'b1;
        end
        check("abort.no_redirect", 32'(seen), 32'd0);
        check("abort.depth_after", 32'(depth), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
